// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared phase indices and register-file sizing defaults
package reg_file_pkg;
  localparam int PH_F = 0;
  localparam int PH_R = 1;
  localparam int PH_X = 2;
  localparam int PH_M = 3;
  localparam int PH_W = 4;
  localparam int NPH = 5;
  localparam int DW_DEF = 32;
  localparam int AW_DEF = 3;
endpackage

// File: rtl/phase_chk.sv
// phase_chk: flags whether a pipeline phase vector has exactly one bit set
module phase_chk
  import reg_file_pkg::*;
(
  input  logic [NPH-1:0] phase,
  output logic           legal
);
  always_comb legal = $onehot(phase);
endmodule

// File: rtl/reg_file.sv
// reg_file: 8-entry phase-sequenced register file with registered dual read ports
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NPH-1:0] phase,
  input  logic [AW-1:0]  ra1,
  input  logic [AW-1:0]  ra2,
  input  logic           we,
  input  logic [AW-1:0]  wa,
  input  logic [DW-1:0]  wd,
  output logic [DW-1:0]  rd1,
  output logic [DW-1:0]  rd2,
  output logic           rd_valid,
  output logic           phase_err
);
  localparam int NR = 1 << AW;
  logic [DW-1:0] regs [NR];
  logic legal;
  phase_chk u_chk (.phase(phase), .legal(legal));
  // an illegal phase freezes all state except the sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) regs[i] <= '0;
      rd1 <= '0;
      rd2 <= '0;
      rd_valid <= 1'b0;
      phase_err <= 1'b0;
    end else if (!legal) begin
      phase_err <= 1'b1;
    end else begin
      if (phase[PH_X]) begin
        rd1 <= regs[ra1];
        rd2 <= regs[ra2];
        rd_valid <= 1'b1;
      end
      if (phase[PH_F]) rd_valid <= 1'b0;
      if (phase[PH_W] && we) regs[wa] <= wd;
    end
  end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file
module tb_reg_file;
  localparam logic [4:0] F = 5'b00001, R = 5'b00010, X = 5'b00100, M = 5'b01000, W = 5'b10000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] phase = 5'b0;
  logic [2:0] ra1 = '0, ra2 = '0, wa = '0;
  logic we = 1'b0;
  logic [31:0] wd = '0;
  logic [31:0] rd1, rd2;
  logic rd_valid, phase_err;
  int passed = 0;
  int total = 0;

  reg_file dut (.clk(clk), .rst(rst), .phase(phase), .ra1(ra1), .ra2(ra2), .we(we),
                .wa(wa), .wd(wd), .rd1(rd1), .rd2(rd2), .rd_valid(rd_valid), .phase_err(phase_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick(input logic [4:0] ph);
    phase = ph;
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic w_en, input logic [2:0] w_a, input logic [31:0] w_d,
                       input logic [2:0] a1, input logic [2:0] a2);
    we = 1'b0; wa = w_a; wd = w_d; ra1 = a1; ra2 = a2;
    tick(F); tick(R); tick(X); tick(M);
    we = w_en;
    tick(W);
    we = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd1", rd1, 32'h0);
    chk("rst_rd2", rd2, 32'h0);
    chk("rst_valid", {31'b0, rd_valid}, 32'h0);
    chk("rst_err", {31'b0, phase_err}, 32'h0);
    rst = 1'b0;
    for (int a = 0; a < 8; a += 2) begin
      instr(1'b0, 3'd0, 32'h0, 3'(a), 3'(a + 1));
      chk($sformatf("rst_read_%0d", a), rd1, 32'h0);
      chk($sformatf("rst_read_%0d", a + 1), rd2, 32'h0);
    end
    instr(1'b1, 3'd5, 32'hDEADBEEF, 3'd0, 3'd0);
    ra1 = 3'd5; ra2 = 3'd0;
    tick(F); tick(R);
    chk("wr_valid_pre_x", {31'b0, rd_valid}, 32'h0);
    tick(X);
    chk("wr_rd1", rd1, 32'hDEADBEEF);
    chk("wr_rd2", rd2, 32'h0);
    chk("wr_valid_x", {31'b0, rd_valid}, 32'h1);
    tick(M); tick(W);
    chk("wr_valid_w", {31'b0, rd_valid}, 32'h1);
    tick(F);
    chk("wr_valid_f", {31'b0, rd_valid}, 32'h0);
    chk("wr_hold_f", rd1, 32'hDEADBEEF);
    we = 1'b1; wa = 3'd3; wd = 32'h1234;
    tick(R); tick(X); tick(M);
    we = 1'b0;
    tick(W);
    we = 1'b1;
    tick(F);
    we = 1'b0;
    tick(R); tick(M); tick(W);
    instr(1'b0, 3'd0, 32'h0, 3'd3, 3'd5);
    chk("gated_rd1", rd1, 32'h0);
    chk("gated_rd2", rd2, 32'hDEADBEEF);
    instr(1'b1, 3'd0, 32'h0BADF00D, 3'd3, 3'd3);
    instr(1'b0, 3'd0, 32'h0, 3'd0, 3'd5);
    chk("reg0_rd1", rd1, 32'h0BADF00D);
    chk("reg0_rd2", rd2, 32'hDEADBEEF);
    we = 1'b1; wa = 3'd6; wd = 32'hFFFF; ra1 = 3'd3; ra2 = 3'd3;
    tick(5'b00110);
    chk("ill_err", {31'b0, phase_err}, 32'h1);
    chk("ill_rd1", rd1, 32'h0BADF00D);
    chk("ill_rd2", rd2, 32'hDEADBEEF);
    chk("ill_valid", {31'b0, rd_valid}, 32'h1);
    tick(5'b00000);
    chk("zero_valid", {31'b0, rd_valid}, 32'h1);
    tick(5'b10001);
    chk("both_fw_valid", {31'b0, rd_valid}, 32'h1);
    we = 1'b0;
    for (int i = 0; i < 10; i++) instr(1'b0, 3'd0, 32'h0, 3'd1, 3'd2);
    chk("err_sticky", {31'b0, phase_err}, 32'h1);
    instr(1'b0, 3'd0, 32'h0, 3'd6, 3'd0);
    chk("ill_nowrite", rd1, 32'h0);
    chk("ill_reg0_kept", rd2, 32'h0BADF00D);
    instr(1'b1, 3'd7, 32'hA5A5A5A5, 3'd0, 3'd0);
    instr(1'b0, 3'd0, 32'h0, 3'd7, 3'd7);
    chk("same_rd1", rd1, 32'hA5A5A5A5);
    chk("same_rd2", rd2, 32'hA5A5A5A5);
    ra1 = 3'd7; ra2 = 3'd5;
    tick(F); tick(R); tick(X);
    chk("pre_rst_rd1", rd1, 32'hA5A5A5A5);
    phase = M; we = 1'b1; wa = 3'd4; wd = 32'h77;
    #2 rst = 1'b1;
    #1;
    chk("async_rd1", rd1, 32'h0);
    chk("async_valid", {31'b0, rd_valid}, 32'h0);
    chk("async_err", {31'b0, phase_err}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    we = 1'b0;
    chk("post_rst_valid", {31'b0, rd_valid}, 32'h0);
    instr(1'b1, 3'd2, 32'h55, 3'd0, 3'd0);
    instr(1'b0, 3'd0, 32'h0, 3'd2, 3'd7);
    chk("mid_rd1", rd1, 32'h55);
    chk("mid_rd2", rd2, 32'h0);
    instr(1'b0, 3'd0, 32'h0, 3'd4, 3'd5);
    chk("mid_abort", rd1, 32'h0);
    chk("mid_cleared", rd2, 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DW, default 32: register data width in bits.
REQ-002 Parameter AW, default 3: register address width; the file holds 2**AW = 8 registers.
REQ-003 clk  input  1  system clock; all state changes on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 phase  input  5  one-hot pipeline phase; bit indices f=0, r=1, x=2, m=3, w=4.
REQ-006 ra1  input  AW  read address, port 1; stable during phase x (the instruction decoder registers it on the posedge in phase r).
REQ-007 ra2  input  AW  read address, port 2; same timing as ra1.
REQ-008 we  input  1  write enable; sampled in phase w only.
REQ-009 wa  input  AW  write address.
REQ-010 wd  input  DW  write data.
REQ-011 rd1  output  DW  registered read data, port 1.
REQ-012 rd2  output  DW  registered read data, port 2.
REQ-013 rd_valid  output  1  rd1/rd2 hold data for the current instruction.
REQ-014 phase_err  output  1  sticky flag; set when phase is not one-hot.

Function
REQ-015 A legal phase SHALL have exactly one bit set; any other value, including zero, SHALL be illegal.
REQ-016 On a posedge with a legal phase and phase[x]=1: rd1 <= regs[ra1], rd2 <= regs[ra2], rd_valid <= 1.
REQ-017 On a posedge with a legal phase and phase[f]=1: rd_valid <= 0; rd1/rd2 SHALL hold their values.
REQ-018 On a posedge with a legal phase, phase[w]=1 and we=1: regs[wa] <= wd.
REQ-019 we SHALL be ignored in every phase other than w.
REQ-020 Read latency SHALL be 1 cycle: rd1/rd2 are valid from the posedge ending phase x through the next phase f edge, covering phases m and w.
REQ-021 Reads and writes SHALL never coincide under legal phases; no bypass path SHALL exist.
REQ-022 Write-then-read to the same address SHALL return the new value in the next instruction, since its x phase follows the w phase.
REQ-023 ra1 = ra2 SHALL give identical rd1 and rd2.
REQ-024 Register 0 SHALL be writable like any other register; there SHALL be no hardwired zero.
REQ-025 On a posedge with an illegal phase: phase_err <= 1, with no register write and no change to rd1, rd2 or rd_valid.
REQ-026 phase_err SHALL clear only on rst.
REQ-027 Unknown or X bits on ra1, ra2 or wa outside their active phase SHALL have no effect.

Reset
REQ-028 While rst=1, asynchronously: all 8 registers = 0, rd1 = 0, rd2 = 0, rd_valid = 0, phase_err = 0.
REQ-029 Reset asserted mid-instruction SHALL abort any pending write, and the first posedge after deassertion SHALL obey REQ-015..025 for the phase presented.

Structure
REQ-030 Phase bit indices (f, r, x, m, w) and the AW/DW defaults SHALL live in the shared definitions package used by the instruction decoder and the phase sequencer.
REQ-031 The one-hot legality check SHALL be a sub-module, phase_chk (input phase, output legal), reusable by other phase consumers.
REQ-032 The storage array SHALL be a single 8 x DW register array inside reg_file.

Verification
REQ-033 Reset: hold rst=1 for 2 cycles -> rd1 = rd2 = 0, rd_valid = 0, phase_err = 0; a read of each address in phase x returns 0.
REQ-034 Write/read: phase w, we=1, wa=5, wd=0xDEADBEEF; next instruction phase x, ra1=5, ra2=0 -> rd1 = 0xDEADBEEF, rd2 = 0, rd_valid = 1 through phase w, rd_valid = 0 after phase f.
REQ-035 Gated write: we=1, wa=3, wd=0x1234 presented in phases f, r, x and m -> a later read of address 3 returns 0.
REQ-036 Illegal phase: phase=5'b00110 with we=1 -> phase_err = 1 and stays 1 over 10 legal instructions; rd1/rd2 unchanged on that edge; no write occurs.
REQ-037 Same-address read: write 0xA5A5A5A5 to address 7, then ra1 = ra2 = 7 in phase x -> rd1 = rd2 = 0xA5A5A5A5.
REQ-038 Reset mid-op: assert rst during phase m after a read, deassert, then run a full f..w sequence writing 0x55 to address 2 -> rd_valid = 0 after reset, and a subsequent read of address 2 returns 0x55.
